// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

  localparam logic [XLEN-1:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP       = 32'd4;

  // One fetched instruction together with the address it came from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_pkt_t;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush loads a bubble, stall holds, otherwise load or bubble.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            load,
  input  fetch_pkt_t      load_pkt,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] instruction,
  output logic            valid
);

  // Flush beats stall; an unstalled cycle without a new instruction inserts a bubble.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      pc          <= '0;
      instruction <= NOP_INSTR;
      valid       <= 1'b0;
    end else if (!stall) begin
      if (load) begin
        pc          <= load_pkt.pc;
        instruction <= load_pkt.instr;
        valid       <= 1'b1;
      end else begin
        instruction <= NOP_INSTR;
        valid       <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, single-outstanding imem handshake, skid buffer, IF/ID.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_stall,
  input  logic            mem_stall,
  input  logic            id_flush,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_instruction,
  output logic            if_id_valid
);

  fetch_state_e    state, state_next;
  logic [XLEN-1:0] pc, pc_next;
  logic [XLEN-1:0] inflight_pc;
  fetch_pkt_t      skid;
  fetch_pkt_t      if_pkt;
  logic            drop, drop_next;
  logic            stall;
  logic            accept;
  logic            if_load;
  logic            skid_we;

  assign stall = id_stall | mem_stall;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_REQ;
    else     state <= state_next;
  end

  // Next-state logic; a flush always returns to S_REQ unless a stale response is still owed.
  always_comb begin
    state_next = state;
    case (state)
      S_REQ: begin
        if (accept) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (drop || id_flush || !stall) state_next = S_REQ;
          else                            state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (id_flush || !stall) state_next = S_REQ;
      end
      default: state_next = S_REQ;
    endcase
  end

  // Output/datapath control: imem handshake, IF/ID load source, PC and drop updates.
  always_comb begin
    imem_req       = (state == S_REQ) && !id_flush;
    imem_addr      = pc;
    accept         = imem_req && imem_ready;
    if_load        = 1'b0;
    if_pkt.pc      = inflight_pc;
    if_pkt.instr   = imem_rdata;
    skid_we        = 1'b0;
    pc_next        = pc;
    drop_next      = drop;
    if (id_flush) begin
      pc_next = redirect_pc;
      if (state == S_WAIT) drop_next = !imem_rvalid;
    end else begin
      case (state)
        S_WAIT: begin
          if (imem_rvalid) begin
            if (drop) begin
              drop_next = 1'b0;
            end else if (!stall) begin
              if_load = 1'b1;
              pc_next = inflight_pc + PC_STEP;
            end else begin
              skid_we = 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (!stall) begin
            if_load = 1'b1;
            if_pkt  = skid;
            pc_next = skid.pc + PC_STEP;
          end
        end
        default: ;
      endcase
    end
  end

  // PC, in-flight address, skid buffer and drop flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      inflight_pc <= RESET_PC;
      skid        <= '0;
      drop        <= 1'b0;
    end else begin
      pc   <= pc_next;
      drop <= drop_next;
      if (accept) inflight_pc <= pc;
      if (id_flush)     skid <= '0;
      else if (skid_we) skid <= if_pkt;
    end
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .flush       (id_flush),
    .load        (if_load),
    .load_pkt    (if_pkt),
    .pc          (if_id_pc),
    .instruction (if_id_instruction),
    .valid       (if_id_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: imem model with scoreboard plus directed pipeline-control checks.
module tb_fetch_stage;
  import fetch_pkg::*;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] MASK = 32'hA5A5_0000;

  logic        clk;
  logic        rst;
  logic        id_stall;
  logic        mem_stall;
  logic        id_flush;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instruction;
  logic        if_id_valid;

  fetch_stage dut (
    .clk               (clk),
    .rst               (rst),
    .id_stall          (id_stall),
    .mem_stall         (mem_stall),
    .id_flush          (id_flush),
    .redirect_pc       (redirect_pc),
    .imem_req          (imem_req),
    .imem_addr         (imem_addr),
    .imem_ready        (imem_ready),
    .imem_rvalid       (imem_rvalid),
    .imem_rdata        (imem_rdata),
    .if_id_pc          (if_id_pc),
    .if_id_instruction (if_id_instruction),
    .if_id_valid       (if_id_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          sb_pops = 0;
  fetch_pkt_t  exp_q[$];

  // imem model state: at most one outstanding request
  logic        mem_busy = 1'b0;
  logic        mem_drop = 1'b0;
  logic [31:0] mem_addr = '0;
  int          mem_cnt  = 0;
  int          lat      = 1;

  logic        req_seen;
  logic [31:0] addr_seen;
  logic        prev_valid = 1'b0;
  logic [31:0] prev_pc = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive imem response at negedge, model acceptance, then observe IF/ID.
  task automatic cycle();
    fetch_pkt_t e;
    logic       acc;
    if (mem_busy && mem_cnt == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_addr ^ MASK;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom();
    end
    #1;
    req_seen  = imem_req;
    addr_seen = imem_addr;
    acc       = imem_req && imem_ready && !rst;
    if (rst) begin
      mem_busy = 1'b0;
      mem_drop = 1'b0;
      exp_q.delete();
    end else begin
      if (id_flush) begin
        if (mem_busy) mem_drop = 1'b1;
        exp_q.delete();
      end
      if (imem_rvalid) begin
        if (!mem_drop) begin
          e.pc    = mem_addr;
          e.instr = imem_rdata;
          exp_q.push_back(e);
        end
        mem_busy = 1'b0;
        mem_drop = 1'b0;
      end else if (mem_busy) begin
        mem_cnt--;
      end
      if (acc) begin
        mem_busy = 1'b1;
        mem_drop = 1'b0;
        mem_addr = addr_seen;
        mem_cnt  = lat - 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    if (if_id_valid && (!prev_valid || if_id_pc != prev_pc)) begin
      check("sb_avail", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        sb_pops++;
        check("sb_pc", if_id_pc, e.pc);
        check("sb_instr", if_id_instruction, e.instr);
      end
    end
    prev_valid = if_id_valid;
    prev_pc    = if_id_pc;
  endtask

  task automatic check_bubble(input string tag);
    check({tag, "_valid"}, 32'(if_id_valid), 32'd0);
    check({tag, "_instr"}, if_id_instruction, NOP);
  endtask

  initial begin
    logic [4:0] vseq;
    rst = 1'b1; id_stall = 1'b0; mem_stall = 1'b0; id_flush = 1'b0;
    redirect_pc = '0; imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    cycle();
    cycle();
    check("rst_pc", if_id_pc, 32'h0);
    check_bubble("rst");
    rst = 1'b0;
    #1;
    check("rst_req", 32'(imem_req), 32'd1);
    check("rst_addr", imem_addr, 32'h0);

    // free run: valid alternates with bubbles
    vseq = 5'b01010;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("run_valid", 32'(if_id_valid), 32'(vseq[4-i]));
    end

    // stall while the response for pc=8 arrives
    id_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("stall_req", 32'(req_seen), 32'd0);
      check("stall_pc", if_id_pc, 32'h4);
    end
    id_stall = 1'b0;
    cycle();
    check("unstall_pc", if_id_pc, 32'h8);
    check("unstall_valid", 32'(if_id_valid), 32'd1);

    // flush while waiting on a 2-cycle response for pc=0xC
    lat = 2;
    cycle();
    check("wait_addr", addr_seen, 32'hC);
    id_flush = 1'b1; redirect_pc = 32'h100;
    cycle();
    check("flush_req", 32'(req_seen), 32'd0);
    check("flush_pc", if_id_pc, 32'h0);
    check_bubble("flush");
    id_flush = 1'b0;
    lat = 1;
    cycle();
    check("drop_req", 32'(req_seen), 32'd0);
    check_bubble("drop");
    cycle();
    check("redir_req", 32'(req_seen), 32'd1);
    check("redir_addr", addr_seen, 32'h100);
    cycle();
    check("redir_pc", if_id_pc, 32'h100);

    // flush and stall together, response arriving in the same cycle
    cycle();
    id_flush = 1'b1; id_stall = 1'b1; mem_stall = 1'b1; redirect_pc = 32'h200;
    cycle();
    check("fs_pc", if_id_pc, 32'h0);
    check_bubble("fs");
    id_flush = 1'b0; id_stall = 1'b0; mem_stall = 1'b0;
    cycle();
    check("fs_addr", addr_seen, 32'h200);
    cycle();
    check("fs_load", if_id_pc, 32'h200);

    // imem not ready for 4 cycles
    imem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("nr_req", 32'(req_seen), 32'd1);
      check("nr_addr", addr_seen, 32'h204);
      check("nr_valid", 32'(if_id_valid), 32'd0);
    end
    imem_ready = 1'b1;
    cycle();
    cycle();
    check("nr_load", if_id_pc, 32'h204);

    // reset while holding a skidded instruction
    cycle();
    mem_stall = 1'b1;
    cycle();
    check("hold_pc", if_id_pc, 32'h204);
    rst = 1'b1;
    cycle();
    check("mrst_pc", if_id_pc, 32'h0);
    check_bubble("mrst");
    rst = 1'b0; mem_stall = 1'b0;
    #1;
    check("mrst_req", 32'(imem_req), 32'd1);
    check("mrst_addr", imem_addr, 32'h0);

    // redirect to the top word: PC wraps to 0
    id_flush = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    cycle();
    check("wrap_flush_req", 32'(req_seen), 32'd0);
    id_flush = 1'b0;
    cycle();
    check("wrap_addr", addr_seen, 32'hFFFF_FFFC);
    cycle();
    check("wrap_pc", if_id_pc, 32'hFFFF_FFFC);
    cycle();
    check("wrap_next", addr_seen, 32'h0);
    cycle();
    check("wrap_load", if_id_pc, 32'h0);
    cycle();

    check("sb_total", 32'(sb_pops), 32'd8);
    check("sb_left", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
